// File: rtl/sram_if_pkg.sv
// Shared constants for logic that drives a sram1024x18 macro port.
//   SRAM_ADDR_W / SRAM_DATA_W : geometry of the macro
//   CEN_IDLE / WEN_IDLE / WMSK_IDLE : pin levels that leave the macro untouched
//   REQ_RD / REQ_WR : encoding of the req_we request-type bit
package sram_if_pkg;

    localparam int SRAM_ADDR_W = 10;
    localparam int SRAM_DATA_W = 18;

    localparam logic                   CEN_IDLE  = 1'b1;
    localparam logic                   WEN_IDLE  = 1'b1;
    localparam logic [SRAM_DATA_W-1:0] WMSK_IDLE = '1;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO holding read data until the consumer takes it.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data     write one entry (caller guarantees not full)
//   pop                 remove the head entry (caller guarantees not empty)
//   pop_data            head entry; stable until the next pop
//   full, empty         occupancy flags
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // NOTE: the storage array has no reset; only pointers and count do. Entries are
    // never read before being written, and an unreset array maps to plain RAM cells.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/sram1024x18_initiator.sv
// Drives one port of a sram1024x18 dual-port macro from a valid/ready request stream
// and returns read data as an in-order, credit-limited response stream.
// Ports:
//   clk, rst                        clock (shared with the SRAM port), async active-high reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr                1 = write / 0 = read, word address
//   req_wdata, req_wmask            write data, active-high per-bit write enable
//   rsp_valid/rsp_ready, rsp_rdata  read response handshake and data, request order
//   sram_cen, sram_wen, sram_wmsk   active-low macro controls (registered)
//   sram_addr, sram_wdata           macro address / write data (registered)
//   sram_rdata                      macro read data, valid the edge after the read is sampled
module sram1024x18_initiator
    import sram_if_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = SRAM_DATA_W,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wmsk,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int                    CNT_W    = $clog2(RSP_DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] WMSK_OFF = {DATA_WIDTH{WMSK_IDLE[0]}};

    logic             accept;
    logic             rd_accept;
    logic             rsp_pop;
    logic             rd_pend;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] out_cnt;

    // Credit check only: one read credit per FIFO slot, writes share the same gate so
    // req_ready never depends on the incoming request.
    assign req_ready = (out_cnt != CNT_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && (req_we == REQ_RD);
    assign rsp_pop   = rsp_valid && rsp_ready;

    // Outstanding reads: accepted but not yet consumed. A read in the pin stage or
    // in flight already owns its FIFO slot, so a push can never find the FIFO full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else begin
            case ({rd_accept, rsp_pop})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Pin stage: one registered cycle per request. Address and write data hold when
    // idle or on reads so the macro inputs toggle only when they carry new information.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_cen   <= CEN_IDLE;
            sram_wen   <= WEN_IDLE;
            sram_wmsk  <= WMSK_OFF;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_cen  <= CEN_IDLE;
            sram_wen  <= WEN_IDLE;
            sram_wmsk <= WMSK_OFF;
            if (accept) begin
                sram_cen  <= ~CEN_IDLE;
                sram_addr <= req_addr;
                if (req_we == REQ_WR) begin
                    sram_wen   <= ~WEN_IDLE;
                    sram_wmsk  <= ~req_wmask;
                    sram_wdata <= req_wdata;
                end
            end
        end
    end

    // The macro samples the pins at the next edge; rd_pend marks that a read was
    // sampled there, so sram_rdata holds its result on the edge after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= (sram_cen != CEN_IDLE) && (sram_wen == WEN_IDLE);
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .push_data (sram_rdata),
        .pop       (rsp_pop),
        .pop_data  (rsp_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(rd_pend && fifo_full));

endmodule

// File: tb/tb_sram1024x18_initiator.sv
// Self-checking bench for sram1024x18_initiator: a behavioural SRAM macro, a
// transaction-level reference model, directed scenarios and a randomized phase.
module tb_sram1024x18_initiator;

    localparam int AW    = 10;
    localparam int DW    = 18;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wmsk;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    int checks = 0;
    int errors = 0;

    sram1024x18_initiator #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wmsk  (sram_wmsk),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Macro: samples pins on the edge, active-low wmsk, rdata changes only on reads.
    logic [DW-1:0] sram_mem [1 << AW];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) begin
                sram_mem[sram_addr] <= (sram_mem[sram_addr] & sram_wmsk) | (sram_wdata & ~sram_wmsk);
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model: memory contents as seen in request order, a queue of pending
    // responses tagged with the edge after which they become visible, and a credit count.
    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] ref_mem [1 << AW];
    int            m_cnt  = 0;
    bit            m_valid = 1'b0;
    int            edge_n = 0;
    bit            m_pop;
    bit            m_acc;
    logic          m_cen  = 1'b1;
    logic          m_wen  = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wmsk = '1;
    logic [DW-1:0] m_wdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_cnt   = 0;
            m_valid = 1'b0;
            m_cen   = 1'b1;
            m_wen   = 1'b1;
            m_wmsk  = '1;
            m_addr  = '0;
            m_wdata = '0;
        end else begin
            m_pop = m_valid && rsp_ready;
            m_acc = req_valid && (m_cnt < DEPTH);
            if (m_pop) begin
                void'(q.pop_front());
                m_cnt--;
            end
            m_cen  = 1'b1;
            m_wen  = 1'b1;
            m_wmsk = '1;
            if (m_acc) begin
                m_cen  = 1'b0;
                m_wen  = !req_we;
                m_addr = req_addr;
                if (req_we) begin
                    ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                    m_wmsk  = ~req_wmask;
                    m_wdata = req_wdata;
                end else begin
                    q.push_back('{ref_mem[req_addr], edge_n + 2});
                    m_cnt++;
                end
            end
            m_valid = (q.size() > 0) && (q[0].avail <= edge_n);
            edge_n++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready", req_ready, m_cnt < DEPTH);
            check("rsp_valid", rsp_valid, m_valid);
            if (m_valid) check("rsp_rdata", rsp_rdata, q[0].data);
            check("sram_cen", sram_cen, m_cen);
            check("sram_wen", sram_wen, m_wen);
            check("sram_wmsk", sram_wmsk, m_wmsk);
            check("sram_addr", sram_addr, m_addr);
            check("sram_wdata", sram_wdata, m_wdata);
        end
    end

    task automatic drive(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] m);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    // Waits (bounded) for the next response; lat counts negedges after the request edge.
    task automatic wait_rsp(input string name, input logic [DW-1:0] exp, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check({name, "_timeout"}, rsp_valid, 1);
        else         check(name, rsp_rdata, exp);
    endtask

    initial begin
        int            lat;
        logic [AW-1:0] a;
        logic [AW-1:0] prev;

        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b0;

        // 1. asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        check("t1_cen", sram_cen, 1);
        check("t1_wen", sram_wen, 1);
        check("t1_wmsk", sram_wmsk, 18'h3FFFF);
        check("t1_rsp_valid", rsp_valid, 0);
        check("t1_req_ready", req_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 2. full write then read back, 3-edge read latency
        @(negedge clk); drive(1'b1, 10'h005, 18'h3FFFF, 18'h3FFFF);
        @(negedge clk); drive(1'b0, 10'h005, 18'h0, 18'h0);
        rsp_ready = 1'b1;
        wait_rsp("t2_rdata", 18'h3FFFF, lat);
        check("t2_latency", lat, 3);

        // 3. partial-mask write merges with previous contents
        @(negedge clk); drive(1'b1, 10'h00A, 18'h00000, 18'h3FFFF);
        @(negedge clk); drive(1'b1, 10'h00A, 18'h2AAAA, 18'h000FF);
        @(negedge clk);
        check("t3_wmsk", sram_wmsk, 18'h3FF00);
        drive(1'b0, 10'h00A, 18'h0, 18'h0);
        wait_rsp("t3_rdata", 18'h000AA, lat);

        // 4. credit limit with consumer stalled
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(1'b1, AW'(i), 18'(32'h100 + i), 18'h3FFFF);
        end
        @(negedge clk); req_valid = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive(1'b0, AW'(i), 18'h0, 18'h0);
        end
        @(negedge clk); req_valid = 1'b0;
        check("t4_ready_low", req_ready, 0);
        @(negedge clk);
        @(negedge clk);
        check("t4_valid", rsp_valid, 1);
        check("t4_data0", rsp_rdata, 18'h100);
        rsp_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) check("t4_ready_back", req_ready, 1);
            check("t4_data", rsp_rdata, 18'(32'h100 + i));
        end
        @(negedge clk);
        check("t4_drained", rsp_valid, 0);

        // 5. write then read on consecutive cycles, then address-wrapping sweep
        @(negedge clk); drive(1'b1, 10'h3FF, 18'h12345, 18'h3FFFF);
        @(negedge clk); drive(1'b0, 10'h3FF, 18'h0, 18'h0);
        wait_rsp("t5_rdata", 18'h12345, lat);
        a    = 10'h3FE;
        prev = 10'h3FE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) check("t5_sweep_addr", sram_addr, prev);
            drive(1'b0, a, 18'h0, 18'h0);
            prev = a;
            a    = a + 1'b1;
        end
        @(negedge clk);
        check("t5_wrap_addr", sram_addr, 10'h001);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);

        // 6. reset with reads outstanding
        rsp_ready = 1'b0;
        @(negedge clk); drive(1'b0, 10'h000, 18'h0, 18'h0);
        @(negedge clk); drive(1'b0, 10'h001, 18'h0, 18'h0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        check("t6_valid_before", rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_valid_reset", rsp_valid, 0);
        check("t6_cen_reset", sram_cen, 1);
        @(negedge clk); rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_no_rsp", rsp_valid, 0);
            check("t6_out_cnt", dut.out_cnt, 0);
        end

        // randomized traffic on a narrow address window to force hazards
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = DW'($urandom);
            req_wmask = DW'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("final_drained", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
